mux4_rr_sched: RTL and testbench
================================

MUX4_RR_SCHED -- requirements
Module: mux4_rr_sched

Interface
REQ-001 Parameter DW, default 2: width of each channel's data and of out_data.
REQ-002 Parameter BURST, default 4, legal range 1..15: maximum beats transferred per grant before forced release.
REQ-003 clk  input  1  single clock; all logic rising-edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  4  per-channel valid; bit n belongs to channel n.
REQ-006 p0, p1, p2, p3  input  DW each  channel 0..3 data.
REQ-007 in_ready  output  4  per-channel ready; at most one bit high in any cycle.
REQ-008 sel  output  2  registered index of the granted channel; drives the downstream 4:1 mux select.
REQ-009 grant_active  output  1  high while a channel holds the grant (state GRANT).
REQ-010 out_valid  output  1  output register holds a beat.
REQ-011 out_data  output  DW  registered beat from the granted channel.
REQ-012 out_ready  input  1  downstream accepts the beat when high together with out_valid.

Function
REQ-013 FSM states: IDLE and GRANT.
REQ-014 IDLE with in_valid != 0: pick the winner by round-robin starting at (last_grant+1) mod 4, then ascending with wrap; next cycle state=GRANT, sel=winner, beat_cnt=0.
REQ-015 IDLE with in_valid == 0: stay IDLE; sel holds its value; in_ready=0.
REQ-016 Arbitration latency: one cycle from in_valid rising in IDLE to grant_active=1.
REQ-017 In GRANT: in_ready[sel] = (!out_valid || out_ready); all other in_ready bits are 0; in_ready is 0 in IDLE.
REQ-018 Transfer = in_valid[sel] && in_ready[sel]; on transfer out_data <= p[sel], out_valid <= 1, beat_cnt increments.
REQ-019 out_valid clears when out_valid && out_ready and no transfer occurs that cycle; a simultaneous drain and transfer keeps out_valid=1 with the new data (full throughput, one beat per cycle).
REQ-020 Grant release, next state IDLE with last_grant <= sel: (a) transfer with beat_cnt == BURST-1; (b) in_valid[sel]=0 in any GRANT cycle.
REQ-021 A stalled granted channel (in_valid[sel]=1, in_ready[sel]=0) keeps the grant indefinitely; beat_cnt does not advance.
REQ-022 BURST=1: release after every transfer; each grant carries exactly one beat.
REQ-023 out_data and out_valid are unaffected by release; the held beat waits for out_ready.
REQ-024 beat_cnt width is 4 bits; no wrap, since it never exceeds BURST-1.

Reset
REQ-025 While rst=1 at a clock edge: state=IDLE, sel=2'd0, last_grant=2'd3 (channel 0 has first priority), beat_cnt=0, out_valid=0, out_data=0.
REQ-026 in_ready=0 and grant_active=0 throughout reset.
REQ-027 Reset asserted mid-burst discards the grant and any beat held in the output register; no beat is emitted after rst falls until a new arbitration completes.

Structure
REQ-028 Package mux_pkg holds: NUM_CH=4, SEL_W=2, the state enumeration (IDLE, GRANT), and the default DW.
REQ-029 One sub-module, rr_pick4: purely combinational, inputs req[3:0] and last[1:0], outputs win[1:0] and any; instantiated once.

Verification
REQ-030 Reset, then in_valid=4'b1111 held and out_ready=1 with BURST=4 -> sel sequence 0,1,2,3,0; four consecutive out_valid beats per grant; one idle (no-transfer) cycle between grants.
REQ-031 Only channel 2 valid with p2=2'b10 and out_ready=1 -> grant_active one cycle after in_valid; out_data=2'b10 with out_valid one cycle after each in_ready[2] transfer.
REQ-032 Channel 1 granted and out_ready=0 for 5 cycles -> one beat held in out_valid; in_ready[1]=0; sel stays 1; beat_cnt stays 1; transfer resumes the cycle out_ready=1.
REQ-033 Channel 3 drops in_valid after 2 beats -> state returns to IDLE next cycle; last_grant=3; next winner is channel 0 if it is valid.
REQ-034 BURST=1 with channels 0 and 2 valid -> grants alternate 0,2,0,2, with exactly one beat each.
REQ-035 rst pulsed during beat 3 of a burst -> out_valid=0 and sel=0 the next cycle; after rst falls, channel 0 wins first.

Source files
------------

// File: rtl/mux4_rr_sched_pkg.sv
// Shared constants and types for the 4-channel round-robin burst multiplexer.
package mux_pkg;

    localparam int NUM_CH     = 4;
    localparam int SEL_W      = 2;
    localparam int BEAT_W     = 4;
    localparam int DEFAULT_DW = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

endpackage

// File: rtl/mux4_rr_sched_rr_pick4.sv
// Combinational round-robin picker: the first requester after 'last', wrapping,
// wins. 'last' itself has the lowest priority.
module rr_pick4
    import mux_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  last,
    output logic [SEL_W-1:0]  win,
    output logic              any
);

    logic [SEL_W-1:0] idx;

    assign any = |req;

    // Walk from lowest to highest priority so that the nearest requester overwrites.
    always_comb begin
        win = '0;
        idx = '0;
        for (int i = NUM_CH; i >= 1; i--) begin
            idx = last + SEL_W'(i);
            if (req[idx]) begin
                win = idx;
            end
        end
    end

endmodule

// File: rtl/mux4_rr_sched.sv
// Four-channel round-robin scheduler with bounded bursts feeding a single
// registered output beat.
module mux4_rr_sched
    import mux_pkg::*;
#(
    parameter int DW    = DEFAULT_DW,
    parameter int BURST = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_CH-1:0]   in_valid,
    input  logic [DW-1:0]       p0,
    input  logic [DW-1:0]       p1,
    input  logic [DW-1:0]       p2,
    input  logic [DW-1:0]       p3,
    output logic [NUM_CH-1:0]   in_ready,
    output logic [SEL_W-1:0]    sel,
    output logic                grant_active,
    output logic                out_valid,
    output logic [DW-1:0]       out_data,
    input  logic                out_ready
);

    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST - 1);

    state_t              state_reg, state_next;
    logic [SEL_W-1:0]    sel_reg, sel_next;
    logic [SEL_W-1:0]    last_reg, last_next;
    logic [BEAT_W-1:0]   beat_cnt_reg, beat_cnt_next;
    logic                out_valid_reg, out_valid_next;
    logic [DW-1:0]       out_data_reg, out_data_next;

    logic [DW-1:0]       p_arr [NUM_CH];
    logic [SEL_W-1:0]    win;
    logic                any;
    logic                granted;
    logic                accept;
    logic                xfer;

    assign p_arr[0] = p0;
    assign p_arr[1] = p1;
    assign p_arr[2] = p2;
    assign p_arr[3] = p3;

    rr_pick4 u_pick (
        .req  (in_valid),
        .last (last_reg),
        .win  (win),
        .any  (any)
    );

    assign granted = (state_reg == GRANT);
    // The output register can take a beat when empty or draining this cycle.
    assign accept  = !out_valid_reg || out_ready;
    assign xfer    = granted && in_valid[sel_reg] && accept;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ready
            assign in_ready[gi] = !rst && granted && accept && (sel_reg == SEL_W'(gi));
        end
    endgenerate

    assign grant_active = granted && !rst;
    assign sel          = sel_reg;
    assign out_valid    = out_valid_reg;
    assign out_data     = out_data_reg;

    always_comb begin
        state_next     = state_reg;
        sel_next       = sel_reg;
        last_next      = last_reg;
        beat_cnt_next  = beat_cnt_reg;
        out_valid_next = out_valid_reg;
        out_data_next  = out_data_reg;

        case (state_reg)
            IDLE: begin
                if (any) begin
                    state_next    = GRANT;
                    sel_next      = win;
                    beat_cnt_next = '0;
                end
            end
            GRANT: begin
                if (!in_valid[sel_reg]) begin
                    state_next = IDLE;
                    last_next  = sel_reg;
                end else if (xfer) begin
                    if (beat_cnt_reg == BEAT_LAST) begin
                        state_next = IDLE;
                        last_next  = sel_reg;
                    end else begin
                        beat_cnt_next = beat_cnt_reg + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        // A release never touches the output register; a held beat still waits.
        if (xfer) begin
            out_valid_next = 1'b1;
            out_data_next  = p_arr[sel_reg];
        end else if (out_valid_reg && out_ready) begin
            out_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            sel_reg       <= '0;
            last_reg      <= SEL_W'(NUM_CH - 1);
            beat_cnt_reg  <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            sel_reg       <= sel_next;
            last_reg      <= last_next;
            beat_cnt_reg  <= beat_cnt_next;
            out_valid_reg <= out_valid_next;
            out_data_reg  <= out_data_next;
        end
    end

endmodule

// File: tb/tb_mux4_rr_sched.sv
// Directed bench for mux4_rr_sched: a BURST=4 instance and a BURST=1 instance
// share one stimulus stream.
module tb_mux4_rr_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] in_valid;
    logic [1:0] p0, p1, p2, p3;
    logic       out_ready;

    logic [3:0] in_ready;
    logic [1:0] sel;
    logic       grant_active;
    logic       out_valid;
    logic [1:0] out_data;

    logic [3:0] b_in_ready;
    logic [1:0] b_sel;
    logic       b_grant_active;
    logic       b_out_valid;
    logic [1:0] b_out_data;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mux4_rr_sched #(.DW(2), .BURST(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .p0           (p0),
        .p1           (p1),
        .p2           (p2),
        .p3           (p3),
        .in_ready     (in_ready),
        .sel          (sel),
        .grant_active (grant_active),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_ready    (out_ready)
    );

    mux4_rr_sched #(.DW(2), .BURST(1)) dut1 (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .p0           (p0),
        .p1           (p1),
        .p2           (p2),
        .p3           (p3),
        .in_ready     (b_in_ready),
        .sel          (b_sel),
        .grant_active (b_grant_active),
        .out_valid    (b_out_valid),
        .out_data     (b_out_data),
        .out_ready    (out_ready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [3:0] m;
        int g;

        // Reset with every channel requesting: nothing may be granted.
        rst = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
        p0 = 2'd0; p1 = 2'd1; p2 = 2'd2; p3 = 2'd3;
        tick(); tick();
        chk("rst_in_ready", in_ready, 4'b0000);
        chk("rst_grant", grant_active, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_sel", sel, 0);
        chk("rst_b_out_valid", b_out_valid, 0);
        $display("reset: in_ready=%b grant=%b out_valid=%b", in_ready, grant_active, out_valid);

        // All channels valid, BURST=4: grants 0,1,2,3,0, four beats each, one gap.
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            g = k % 4;
            m = 4'(1 << g);
            tick();
            chk("rr_grant", grant_active, 1);
            chk("rr_sel", sel, g);
            chk("rr_in_ready", in_ready, m);
            chk("rr_gap_out_valid", out_valid, 0);
            for (int b = 0; b < 4; b++) begin
                tick();
                chk("rr_beat_valid", out_valid, 1);
                chk("rr_beat_data", out_data, g);
                chk("rr_beat_grant", grant_active, (b < 3) ? 1 : 0);
            end
            $display("rr grant %0d: sel=%0d data=%0d", k, sel, out_data);
        end

        // Only channel 2 valid: one-cycle arbitration, data follows p2.
        rst = 1'b1; in_valid = 4'b0000;
        tick();
        rst = 1'b0;
        tick();
        chk("c2_idle_grant", grant_active, 0);
        chk("c2_idle_ready", in_ready, 4'b0000);
        in_valid = 4'b0100; p2 = 2'b10;
        tick();
        chk("c2_grant", grant_active, 1);
        chk("c2_sel", sel, 2);
        chk("c2_in_ready", in_ready, 4'b0100);
        chk("c2_no_beat_yet", out_valid, 0);
        tick();
        chk("c2_beat1_valid", out_valid, 1);
        chk("c2_beat1_data", out_data, 2'b10);
        p2 = 2'b01;
        tick();
        chk("c2_beat2_data", out_data, 2'b01);
        in_valid = 4'b0000;
        tick();
        chk("c2_drop_grant", grant_active, 0);
        chk("c2_drop_out_valid", out_valid, 0);
        $display("ch2 only: grant=%b out_valid=%b", grant_active, out_valid);

        // Channel 1 stalled by out_ready=0 for five cycles after its first beat.
        in_valid = 4'b0010; p1 = 2'b11; out_ready = 1'b1;
        tick();
        chk("st_sel", sel, 1);
        chk("st_grant", grant_active, 1);
        tick();
        chk("st_beat1_data", out_data, 2'b11);
        out_ready = 1'b0; p1 = 2'b01;
        #1;
        chk("st_in_ready_low", in_ready, 4'b0000);
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("st_hold_valid", out_valid, 1);
            chk("st_hold_data", out_data, 2'b11);
            chk("st_hold_sel", sel, 1);
            chk("st_hold_ready", in_ready, 4'b0000);
        end
        out_ready = 1'b1;
        #1;
        chk("st_resume_ready", in_ready, 4'b0010);
        tick();
        chk("st_resume_valid", out_valid, 1);
        chk("st_resume_data", out_data, 2'b01);
        chk("st_resume_grant", grant_active, 1);
        tick();
        chk("st_beat3_grant", grant_active, 1);
        tick();
        chk("st_release", grant_active, 0);
        $display("stall: released after 4 beats, sel=%0d", sel);

        // Channel 3 drops after two beats; channel 0 must win next over channel 2.
        in_valid = 4'b1000; p3 = 2'b10;
        tick();
        chk("d3_sel", sel, 3);
        chk("d3_grant", grant_active, 1);
        chk("d3_prev_drained", out_valid, 0);
        tick();
        tick();
        chk("d3_beat2_data", out_data, 2'b10);
        in_valid = 4'b0101;
        tick();
        chk("d3_idle", grant_active, 0);
        chk("d3_out_valid", out_valid, 0);
        tick();
        chk("d3_next_sel", sel, 0);
        chk("d3_next_grant", grant_active, 1);
        $display("drop ch3: next sel=%0d", sel);

        // Reset during the third beat of a channel 2 burst.
        in_valid = 4'b0100;
        tick();
        chk("rb_release", grant_active, 0);
        tick();
        chk("rb_sel2", sel, 2);
        in_valid = 4'b0101; p2 = 2'b11; p0 = 2'b01;
        tick();
        chk("rb_beat1", out_data, 2'b11);
        tick();
        rst = 1'b1;
        #1;
        chk("rb_rst_ready", in_ready, 4'b0000);
        chk("rb_rst_grant", grant_active, 0);
        tick();
        chk("rb_out_valid", out_valid, 0);
        chk("rb_sel", sel, 0);
        rst = 1'b0;
        tick();
        chk("rb_first_sel", sel, 0);
        chk("rb_first_grant", grant_active, 1);
        chk("rb_no_beat", out_valid, 0);
        tick();
        chk("rb_first_data", out_data, 2'b01);
        $display("reset mid-burst: sel=%0d data=%0d", sel, out_data);

        // BURST=1 instance: channels 0 and 2 alternate with one beat each.
        rst = 1'b1; in_valid = 4'b0101; out_ready = 1'b1; p0 = 2'd1; p2 = 2'd2;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            g = (k % 2) * 2;
            tick();
            chk("b1_grant", b_grant_active, 1);
            chk("b1_sel", b_sel, g);
            chk("b1_gap_valid", b_out_valid, 0);
            tick();
            chk("b1_release", b_grant_active, 0);
            chk("b1_beat_valid", b_out_valid, 1);
            chk("b1_beat_data", b_out_data, (g == 0) ? 1 : 2);
            $display("burst1 grant %0d: sel=%0d data=%0d", k, b_sel, b_out_data);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
